// File: rtl/button_debouncer_if.sv
// button_debouncer_if: raw push-button inputs and debounced level, press and
// auto-repeat pulse outputs with an arbitrated direction code.
interface button_debouncer_if;
    logic [4:0] btn_raw;
    logic [4:0] btn_db;
    logic [4:0] btn_scen;
    logic [4:0] btn_mcen;
    logic       dir_valid;
    logic [2:0] dir_code;

    modport master (
        output btn_raw,
        input  btn_db, btn_scen, btn_mcen, dir_valid, dir_code
    );

    modport slave (
        input  btn_raw,
        output btn_db, btn_scen, btn_mcen, dir_valid, dir_code
    );
endinterface

// File: rtl/button_debouncer.sv
// button_debouncer: five independent two-flop-synchronized debouncers with
// single press pulses, held auto-repeat pulses and a priority direction code.
module button_debouncer #(
    parameter int DB_CYCLES  = 1_000_000,
    parameter int REP_CYCLES = 25_000_000,
    parameter int CNT_W      = 25
) (
    input  logic              clk,
    input  logic              rst,
    button_debouncer_if.slave btn_io
);
    typedef enum logic [1:0] {IDLE, WQ_PRESS, HELD, WQ_REL} state_t;

    localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DB_CYCLES - 1);
    localparam logic [CNT_W-1:0] REP_LAST = CNT_W'(REP_CYCLES - 1);

    logic [4:0] meta_q;
    logic [4:0] sync_q;
    logic [4:0] db_v;
    logic [4:0] scen_v;
    logic [4:0] mcen_v;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= btn_io.btn_raw;
            sync_q <= meta_q;
        end
    end

    for (genvar b = 0; b < 5; b++) begin : g_btn
        state_t           state_q;
        logic [CNT_W-1:0] cnt_q;
        logic             db_q;
        logic             scen_q;
        logic             mcen_q;
        logic             s;

        assign s = sync_q[b];

        // One counter serves as debounce timer in the WQ states and as the
        // auto-repeat timer in HELD; every exit clears it.
        always_ff @(posedge clk) begin
            if (rst) begin
                state_q <= IDLE;
                cnt_q   <= '0;
                db_q    <= 1'b0;
                scen_q  <= 1'b0;
                mcen_q  <= 1'b0;
            end else begin
                scen_q <= 1'b0;
                mcen_q <= 1'b0;
                case (state_q)
                    IDLE: begin
                        cnt_q <= '0;
                        if (s) state_q <= WQ_PRESS;
                    end
                    WQ_PRESS: begin
                        if (!s) begin
                            state_q <= IDLE;
                            cnt_q   <= '0;
                        end else if (cnt_q == DB_LAST) begin
                            state_q <= HELD;
                            cnt_q   <= '0;
                            db_q    <= 1'b1;
                            scen_q  <= 1'b1;
                            mcen_q  <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    HELD: begin
                        if (!s) begin
                            state_q <= WQ_REL;
                            cnt_q   <= '0;
                        end else if (cnt_q == REP_LAST) begin
                            cnt_q  <= '0;
                            mcen_q <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    WQ_REL: begin
                        if (s) begin
                            state_q <= HELD;
                            cnt_q   <= '0;
                        end else if (cnt_q == DB_LAST) begin
                            state_q <= IDLE;
                            cnt_q   <= '0;
                            db_q    <= 1'b0;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                        db_q    <= 1'b0;
                    end
                endcase
            end
        end

        assign db_v[b]   = db_q;
        assign scen_v[b] = scen_q;
        assign mcen_v[b] = mcen_q;
    end

    assign btn_io.btn_db   = db_v;
    assign btn_io.btn_scen = scen_v;
    assign btn_io.btn_mcen = mcen_v;

    always_comb begin
        btn_io.dir_valid = |scen_v;
        btn_io.dir_code  = scen_v[0] ? 3'd0 :
                           scen_v[1] ? 3'd1 :
                           scen_v[2] ? 3'd2 :
                           scen_v[3] ? 3'd3 :
                           scen_v[4] ? 3'd4 : 3'd0;
    end
endmodule

// File: tb/tb_button_debouncer.sv
// tb_button_debouncer: scoreboard bench with DB_CYCLES=4, REP_CYCLES=10;
// expected press/repeat pulses are queued by each scenario and matched per cycle.
module tb_button_debouncer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    button_debouncer_if bus ();

    button_debouncer #(
        .DB_CYCLES (4),
        .REP_CYCLES(10),
        .CNT_W     (4)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .btn_io(bus)
    );

    typedef struct {
        int         cyc;
        logic [4:0] scen;
        logic [4:0] mcen;
    } ev_t;

    ev_t sb[$];
    int  cyc = 0;
    int  checks = 0;
    int  failures = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [2:0] exp_code(logic [4:0] s);
        for (int i = 0; i < 5; i++) if (s[i]) return 3'(i);
        return 3'd0;
    endfunction

    task automatic push_ev(int c, logic [4:0] s, logic [4:0] m);
        ev_t e;
        e.cyc  = c;
        e.scen = s;
        e.mcen = m;
        sb.push_back(e);
    endtask

    task automatic step(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && sb.size() != 0; i++) step(1);
        step(12);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.btn_raw = 5'b0;
        step(3);
        checks++;
        if ({bus.btn_db, bus.btn_scen, bus.btn_mcen} !== 15'b0) begin
            failures++;
            $display("FAIL reset_outputs: got db=%b scen=%b mcen=%b want all 0", bus.btn_db, bus.btn_scen, bus.btn_mcen);
        end
        checks++;
        if ({bus.dir_valid, bus.dir_code} !== 4'b0) begin
            failures++;
            $display("FAIL reset_dir: got valid=%b code=%0d want 0/0", bus.dir_valid, bus.dir_code);
        end
        rst = 1'b0;
        step(2);
    endtask

    task automatic test_clean_press();
        int t;
        t = cyc + 1;
        bus.btn_raw[0] = 1'b1;
        push_ev(t + 6, 5'b00001, 5'b00001);
        push_ev(t + 16, 5'b00000, 5'b00001);
        push_ev(t + 26, 5'b00000, 5'b00001);
        step(5);
        checks++;
        if (bus.btn_db[0] !== 1'b0) begin
            failures++;
            $display("FAIL press_db_early: got %b want 0", bus.btn_db[0]);
        end
        step(2);
        checks++;
        if (bus.btn_db[0] !== 1'b1) begin
            failures++;
            $display("FAIL press_db: got %b want 1", bus.btn_db[0]);
        end
        checks++;
        if (bus.dir_valid !== 1'b1 || bus.dir_code !== 3'd0) begin
            failures++;
            $display("FAIL press_dir: got valid=%b code=%0d want 1/0", bus.dir_valid, bus.dir_code);
        end
        step(23);
        bus.btn_raw[0] = 1'b0;
        step(6);
        checks++;
        if (bus.btn_db[0] !== 1'b1) begin
            failures++;
            $display("FAIL release_db_hold: got %b want 1", bus.btn_db[0]);
        end
        step(1);
        checks++;
        if (bus.btn_db[0] !== 1'b0) begin
            failures++;
            $display("FAIL release_db: got %b want 0", bus.btn_db[0]);
        end
        drain();
    endtask

    task automatic test_bounce();
        int t;
        for (int i = 0; i < 4; i++) begin
            bus.btn_raw[2] = (i % 2 == 0);
            step(1);
        end
        t = cyc + 1;
        bus.btn_raw[2] = 1'b1;
        push_ev(t + 6, 5'b00100, 5'b00100);
        step(5);
        checks++;
        if (bus.btn_db[2] !== 1'b0) begin
            failures++;
            $display("FAIL bounce_db_early: got %b want 0", bus.btn_db[2]);
        end
        step(2);
        checks++;
        if (bus.btn_db[2] !== 1'b1) begin
            failures++;
            $display("FAIL bounce_db: got %b want 1", bus.btn_db[2]);
        end
        step(2);
        bus.btn_raw[2] = 1'b0;
        drain();
    endtask

    task automatic test_release_bounce();
        int t;
        int d;
        int e;
        t = cyc + 1;
        bus.btn_raw[1] = 1'b1;
        push_ev(t + 6, 5'b00010, 5'b00010);
        step(7);
        d = cyc;
        bus.btn_raw[1] = 1'b0;
        step(2);
        bus.btn_raw[1] = 1'b1;
        push_ev(d + 15, 5'b00000, 5'b00010);
        for (int i = 0; i < 10; i++) begin
            step(1);
            checks++;
            if (bus.btn_db[1] !== 1'b1) begin
                failures++;
                $display("FAIL relbounce_db: got %b want 1 at cycle %0d", bus.btn_db[1], cyc);
            end
        end
        step(4);
        e = cyc;
        bus.btn_raw[1] = 1'b0;
        step(6);
        checks++;
        if (bus.btn_db[1] !== 1'b1) begin
            failures++;
            $display("FAIL relbounce_db_hold: got %b want 1 at cycle %0d", bus.btn_db[1], cyc - e);
        end
        step(1);
        checks++;
        if (bus.btn_db[1] !== 1'b0) begin
            failures++;
            $display("FAIL relbounce_db_fall: got %b want 0", bus.btn_db[1]);
        end
        drain();
    endtask

    task automatic test_simultaneous();
        int t;
        t = cyc + 1;
        bus.btn_raw = 5'b01010;
        push_ev(t + 6, 5'b01010, 5'b01010);
        step(7);
        checks++;
        if (bus.dir_valid !== 1'b1 || bus.dir_code !== 3'd1) begin
            failures++;
            $display("FAIL simul_dir: got valid=%b code=%0d want 1/1", bus.dir_valid, bus.dir_code);
        end
        step(2);
        bus.btn_raw = 5'b0;
        drain();
    endtask

    task automatic test_glitch();
        int t;
        bus.btn_raw[3] = 1'b1;
        step(4);
        bus.btn_raw[3] = 1'b0;
        step(10);
        checks++;
        if (bus.btn_db[3] !== 1'b0) begin
            failures++;
            $display("FAIL glitch_db: got %b want 0", bus.btn_db[3]);
        end
        t = cyc + 1;
        bus.btn_raw[3] = 1'b1;
        push_ev(t + 6, 5'b01000, 5'b01000);
        step(5);
        bus.btn_raw[3] = 1'b0;
        drain();
    endtask

    task automatic test_reset_mid_hold();
        int t;
        int a;
        t = cyc + 1;
        bus.btn_raw[4] = 1'b1;
        push_ev(t + 6, 5'b10000, 5'b10000);
        step(9);
        a = cyc;
        rst = 1'b1;
        step(1);
        checks++;
        if ({bus.btn_db, bus.btn_scen, bus.btn_mcen, bus.dir_valid, bus.dir_code} !== 19'b0) begin
            failures++;
            $display("FAIL midhold_reset: got db=%b scen=%b mcen=%b valid=%b code=%0d want all 0",
                     bus.btn_db, bus.btn_scen, bus.btn_mcen, bus.dir_valid, bus.dir_code);
        end
        rst = 1'b0;
        push_ev(a + 8, 5'b10000, 5'b10000);
        step(6);
        checks++;
        if (bus.btn_db[4] !== 1'b0) begin
            failures++;
            $display("FAIL midhold_db_early: got %b want 0", bus.btn_db[4]);
        end
        step(1);
        checks++;
        if (bus.btn_db[4] !== 1'b1) begin
            failures++;
            $display("FAIL midhold_db: got %b want 1", bus.btn_db[4]);
        end
        step(2);
        bus.btn_raw[4] = 1'b0;
        drain();
    endtask

    initial begin
        bus.btn_raw = 5'b0;
        fork
            begin : monitor
                ev_t e;
                forever begin
                    @(negedge clk);
                    while (sb.size() != 0 && sb[0].cyc < cyc) begin
                        checks++;
                        failures++;
                        $display("FAIL sb_missed: pulse scen=%b mcen=%b due at cycle %0d not seen (now %0d)",
                                 sb[0].scen, sb[0].mcen, sb[0].cyc, cyc);
                        sb.delete(0);
                    end
                    if ((bus.btn_scen | bus.btn_mcen) != 5'b0) begin
                        checks++;
                        if (sb.size() != 0 && sb[0].cyc == cyc) begin
                            e = sb.pop_front();
                            if (bus.btn_scen !== e.scen || bus.btn_mcen !== e.mcen) begin
                                failures++;
                                $display("FAIL sb_pulse: cycle %0d got scen=%b mcen=%b want scen=%b mcen=%b",
                                         cyc, bus.btn_scen, bus.btn_mcen, e.scen, e.mcen);
                            end
                            checks++;
                            if (bus.dir_valid !== (|e.scen) || bus.dir_code !== exp_code(e.scen)) begin
                                failures++;
                                $display("FAIL sb_dir: cycle %0d got valid=%b code=%0d want valid=%b code=%0d",
                                         cyc, bus.dir_valid, bus.dir_code, |e.scen, exp_code(e.scen));
                            end
                        end else begin
                            failures++;
                            $display("FAIL sb_unexpected: cycle %0d got scen=%b mcen=%b want none",
                                     cyc, bus.btn_scen, bus.btn_mcen);
                        end
                    end else begin
                        checks++;
                        if (bus.dir_valid !== 1'b0 || bus.dir_code !== 3'd0) begin
                            failures++;
                            $display("FAIL idle_dir: cycle %0d got valid=%b code=%0d want 0/0",
                                     cyc, bus.dir_valid, bus.dir_code);
                        end
                    end
                end
            end
        join_none

        test_reset();
        test_clean_press();
        test_bounce();
        test_release_bounce();
        test_simultaneous();
        test_glitch();
        test_reset_mid_hold();
        step(3);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL sb_leftover: got %0d pending pulses want 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/button_debouncer.md
BUTTON_DEBOUNCER -- requirements
Module: button_debouncer

Interface
REQ-001 Parameter DB_CYCLES, 1_000_000, number of consecutive stable synchronized samples required to accept a level change (10 ms at 100 MHz).
REQ-002 Parameter REP_CYCLES, 25_000_000, held-button auto-repeat period in clocks.
REQ-003 Parameter CNT_W, 25, width of each per-button counter; the counter must be wide enough to hold max(DB_CYCLES, REP_CYCLES).
REQ-004 clk  input  1  single clock for all logic.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 btn_raw  input  5  asynchronous push buttons: bit0 right, bit1 left, bit2 up, bit3 down, bit4 center.
REQ-007 btn_db  output  5  debounced level per button.
REQ-008 btn_scen  output  5  single-cycle pulse per accepted press.
REQ-009 btn_mcen  output  5  press pulse plus one pulse every REP_CYCLES while the button is held.
REQ-010 dir_valid  output  1  any btn_scen bit asserted this cycle.
REQ-011 dir_code  output  3  arbitrated press: 0 right, 1 left, 2 up, 3 down, 4 center; 0 when dir_valid=0.

Function
REQ-012 Each btn_raw bit SHALL pass through a two-flop synchronizer; FSMs see only the second flop (sync).
REQ-013 Each button SHALL have an independent FSM with states IDLE, WQ_PRESS, HELD, WQ_REL, plus a CNT_W-bit counter.
REQ-014 IDLE: counter=0; sync=1 -> WQ_PRESS.
REQ-015 WQ_PRESS: counter increments while sync=1; sync=0 -> IDLE with counter cleared; counter reaching DB_CYCLES-1 with sync=1 -> HELD with counter cleared.
REQ-016 On the transition WQ_PRESS->HELD, btn_scen and btn_mcen for that bit SHALL pulse high for exactly one cycle (registered) while HELD is entered.
REQ-017 Press latency SHALL be: raw high stable from edge at cycle t -> btn_scen high in cycle t+2+DB_CYCLES, btn_db high from the same cycle.
REQ-018 HELD: btn_db=1; repeat counter increments; on reaching REP_CYCLES-1, btn_mcen pulses one cycle and the counter wraps to 0; sync=0 -> WQ_REL with counter cleared.
REQ-019 WQ_REL: btn_db stays 1; counter increments while sync=0; sync=1 -> HELD with repeat counter cleared and no new btn_scen; counter reaching DB_CYCLES-1 -> IDLE, btn_db=0 from the next cycle.
REQ-020 Glitches shorter than DB_CYCLES SHALL never produce btn_scen or change btn_db.
REQ-021 dir_valid/dir_code SHALL be combinational from btn_scen, priority right > left > up > down > center; lower-priority simultaneous presses are still reported on btn_scen but are dropped from dir_code.
REQ-022 Counters SHALL saturate-free wrap only as specified; no other counter overflow is permitted (counter never exceeds its terminal value).
REQ-023 Buttons SHALL be fully independent; activity on one bit never alters another bit's FSM or counter.

Reset
REQ-024 With rst=1 at a clk edge: synchronizer flops 0, all FSMs IDLE, all counters 0, btn_db/btn_scen/btn_mcen = 0, hence dir_valid=0 and dir_code=0.
REQ-025 Reset SHALL override all transitions, including mid-debounce and mid-repeat.
REQ-026 A button held through reset deassertion SHALL be re-debounced from IDLE: btn_scen fires 2+DB_CYCLES cycles after rst falls.

Verification (DB_CYCLES=4, REP_CYCLES=10, CNT_W=4)
REQ-027 Clean press: btn_raw[0] 0->1 at cycle 0 and held 30 cycles -> btn_scen[0]=1 only in cycle 6; btn_mcen[0] pulses in cycles 6, 16, and 26; dir_valid=1 and dir_code=0 in cycle 6.
REQ-028 Bounce: btn_raw[2] toggles 1,0,1,0 every cycle, then is held high -> no btn_scen during the bounce; exactly one btn_scen[2] pulse 6 cycles after the final rise.
REQ-029 Release bounce: while HELD, btn_raw[1] drops for 2 cycles and returns high -> btn_db[1] stays 1, no new btn_scen[1]; a full release -> btn_db[1]=0 after 2+4 cycles.
REQ-030 Simultaneous: btn_raw[3] and btn_raw[1] rise in the same cycle -> btn_scen=5'b01010 in cycle 6, dir_code=1.
REQ-031 Reset mid-hold: rst is asserted for 1 cycle while btn_raw[4] is HELD and kept high -> all outputs are 0 the cycle after the reset edge; btn_scen[4] pulses 6 cycles after rst is released.
